// File: rtl/fifo_cdc.sv
// Dual-clock byte FIFO with Gray-coded pointer crossing and first-word fall-through output.
// Full and empty flags are registered in their own domains and are conservative during synchronizer latency.
module fifo_cdc #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              rstn_i,
    input  logic              iclk_i,
    input  logic              oclk_i,
    input  logic [DATA_W-1:0] idata_i,
    input  logic              ivalid_i,
    output logic              iready_o,
    output logic [DATA_W-1:0] odata_o,
    output logic              ovalid_o,
    input  logic              oready_i
);

    localparam int DEPTH = 32'd1 << ADDR_W;

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] bin);
        return bin ^ (bin >> 1'b1);
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [ADDR_W:0] wbin_r, wgray_r, rgray_sync1_r, rgray_sync2_r;
    logic [ADDR_W:0] rbin_r, rgray_r, wgray_sync1_r, wgray_sync2_r;
    logic            iready_r, ovalid_r;

    logic            wr_en_s, rd_en_s, full_next_s, empty_next_s;
    logic [ADDR_W:0] wbin_next_s, wgray_next_s, rbin_next_s, rgray_next_s;

    // Write-side next state; full compares against the read pointer with its two MSBs flipped
    always_comb begin
        wr_en_s      = ivalid_i & iready_r;
        wbin_next_s  = wbin_r + {{ADDR_W{1'b0}}, wr_en_s};
        wgray_next_s = bin2gray(wbin_next_s);
        full_next_s  = (wgray_next_s ==
                        {~rgray_sync2_r[ADDR_W:ADDR_W-1], rgray_sync2_r[ADDR_W-2:0]});
    end

    // Write-side pointers, read-pointer synchronizer and registered ready
    always_ff @(posedge iclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wbin_r        <= {(ADDR_W+1){1'b0}};
            wgray_r       <= {(ADDR_W+1){1'b0}};
            rgray_sync1_r <= {(ADDR_W+1){1'b0}};
            rgray_sync2_r <= {(ADDR_W+1){1'b0}};
            iready_r      <= 1'b1;
        end else begin
            wbin_r        <= wbin_next_s;
            wgray_r       <= wgray_next_s;
            rgray_sync1_r <= rgray_r;
            rgray_sync2_r <= rgray_sync1_r;
            iready_r      <= ~full_next_s;
        end
    end

    // Storage is deliberately left unreset
    always_ff @(posedge iclk_i) begin
        if (wr_en_s) begin
            mem_r[wbin_r[ADDR_W-1:0]] <= idata_i;
        end
    end

    // Read-side next state; empty when the advanced read pointer meets the synchronized write pointer
    always_comb begin
        rd_en_s      = ovalid_r & oready_i;
        rbin_next_s  = rbin_r + {{ADDR_W{1'b0}}, rd_en_s};
        rgray_next_s = bin2gray(rbin_next_s);
        empty_next_s = (rgray_next_s == wgray_sync2_r);
    end

    // Read-side pointers, write-pointer synchronizer and registered valid
    always_ff @(posedge oclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rbin_r        <= {(ADDR_W+1){1'b0}};
            rgray_r       <= {(ADDR_W+1){1'b0}};
            wgray_sync1_r <= {(ADDR_W+1){1'b0}};
            wgray_sync2_r <= {(ADDR_W+1){1'b0}};
            ovalid_r      <= 1'b0;
        end else begin
            rbin_r        <= rbin_next_s;
            rgray_r       <= rgray_next_s;
            wgray_sync1_r <= wgray_r;
            wgray_sync2_r <= wgray_sync1_r;
            ovalid_r      <= ~empty_next_s;
        end
    end

    assign iready_o = iready_r;
    assign ovalid_o = ovalid_r;
    assign odata_o  = mem_r[rbin_r[ADDR_W-1:0]];

endmodule

// File: tb/tb_fifo_cdc.sv
// Scoreboard bench for fifo_cdc: accepted writes are queued, every pop is compared in order.
// Clock edges of the two domains never coincide (even vs odd time stamps).
module tb_fifo_cdc;

    logic       rstn, iclk, oclk;
    logic [7:0] idata, odata;
    logic       ivalid, iready, ovalid, oready;

    int ih = 6;
    int oh = 8;
    int total = 0;
    int bad = 0;
    int rd_mode = 0;
    int pop_cnt = 0;
    logic [7:0] exp_q[$];

    fifo_cdc #(.DATA_W(8), .ADDR_W(3)) dut (
        .rstn_i(rstn), .iclk_i(iclk), .oclk_i(oclk),
        .idata_i(idata), .ivalid_i(ivalid), .iready_o(iready),
        .odata_o(odata), .ovalid_o(ovalid), .oready_i(oready)
    );

    initial begin
        iclk = 1'b0;
        forever #(ih) iclk = ~iclk;
    end

    initial begin
        oclk = 1'b0;
        #1;
        forever #(oh) oclk = ~oclk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reader: decides oready on the falling edge and checks the word that the next rising edge pops
    initial begin
        oready = 1'b0;
        forever begin
            @(negedge oclk);
            if (!rstn) begin
                oready = 1'b0;
            end else begin
                case (rd_mode)
                    1:       oready = 1'($urandom_range(0, 1));
                    2:       oready = 1'b1;
                    default: oready = 1'b0;
                endcase
                if (ovalid && oready) begin
                    pop_cnt++;
                    if (exp_q.size() == 0) check_val("spurious_pop", 32'(odata), 32'hFFFF_FFFF);
                    else check_val("pop_data", 32'(odata), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Called on an iclk falling edge; returns on the falling edge after the transfer
    task automatic push_byte(input logic [7:0] d);
        int n = 0;
        idata  = d;
        ivalid = 1'b1;
        while (!iready && n < 200) begin
            @(negedge iclk);
            n++;
        end
        if (!iready) check_val("wr_timeout", 32'(iready), 32'd1);
        else exp_q.push_back(d);
        @(negedge iclk);
        ivalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge oclk);
            n++;
        end
        check_val(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int lat;
        int base;
        rstn   = 1'b0;
        ivalid = 1'b0;
        idata  = 8'h00;
        repeat (3) @(negedge iclk);
        check_val("rst_iready", 32'(iready), 32'd1);
        check_val("rst_ovalid", 32'(ovalid), 32'd0);
        rstn = 1'b1;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            @(posedge oclk);
            #1;
            check_val("idle_ovalid", 32'(ovalid), 32'd0);
            check_val("idle_iready", 32'(iready), 32'd1);
        end

        // Single byte latency and hold
        rd_mode = 0;
        @(negedge iclk);
        check_val("a5_iready", 32'(iready), 32'd1);
        idata  = 8'hA5;
        ivalid = 1'b1;
        exp_q.push_back(8'hA5);
        @(posedge iclk);
        fork
            begin #1; ivalid = 1'b0; end
        join_none
        check_val("a5_not_early", 32'(ovalid), 32'd0);
        lat = 0;
        while (!ovalid && lat < 6) begin
            @(posedge oclk);
            #1;
            lat++;
        end
        check_val("a5_lat_min", 32'(lat >= 2), 32'd1);
        check_val("a5_lat_max", 32'(lat <= 3), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge oclk);
            #1;
            check_val("a5_hold_valid", 32'(ovalid), 32'd1);
            check_val("a5_hold_data", 32'(odata), 32'hA5);
        end
        rd_mode = 2;
        drain("a5_drain");
        rd_mode = 0;
        repeat (4) @(posedge oclk);
        #1;
        check_val("a5_empty", 32'(ovalid), 32'd0);

        // Fill to full, overflow attempt, drain
        @(negedge iclk);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check_val("fill_not_full", 32'(iready), 32'd1);
            push_byte(8'(i));
        end
        check_val("full_iready", 32'(iready), 32'd0);
        idata  = 8'h08;
        ivalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge iclk);
            check_val("ovf_iready", 32'(iready), 32'd0);
        end
        ivalid  = 1'b0;
        base    = pop_cnt;
        rd_mode = 2;
        drain("fill_drain");
        repeat (10) @(posedge oclk);
        #1;
        check_val("fill_pops", 32'(pop_cnt - base), 32'd8);
        check_val("fill_empty", 32'(ovalid), 32'd0);
        lat = 0;
        while (!iready && lat < 10) begin
            @(posedge iclk);
            #1;
            lat++;
        end
        check_val("fill_ready_back", 32'(iready), 32'd1);

        // Rate-mismatched random stream, fast write side then fast read side
        rd_mode = 1;
        base    = pop_cnt;
        ih      = 6;
        oh      = 24;
        @(negedge iclk);
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                ih = 24;
                oh = 6;
            end
            repeat ($urandom_range(0, 1)) @(negedge iclk);
            push_byte(8'(i));
        end
        drain("stream_drain");
        check_val("stream_pops", 32'(pop_cnt - base), 32'd1000);
        ih = 6;
        oh = 8;

        // Reset mid-stream discards queued data
        rd_mode = 0;
        @(negedge iclk);
        for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
        lat = 0;
        while (!ovalid && lat < 10) begin
            @(posedge oclk);
            #1;
            lat++;
        end
        check_val("mid_valid", 32'(ovalid), 32'd1);
        #3;
        rstn = 1'b0;
        #1;
        check_val("mid_rst_ovalid", 32'(ovalid), 32'd0);
        check_val("mid_rst_iready", 32'(iready), 32'd1);
        exp_q.delete();
        repeat (2) @(negedge iclk);
        rstn = 1'b1;
        base = pop_cnt;
        push_byte(8'h3C);
        rd_mode = 2;
        drain("post_rst_drain");
        repeat (6) @(posedge oclk);
        #1;
        check_val("post_rst_pops", 32'(pop_cnt - base), 32'd1);
        check_val("post_rst_empty", 32'(ovalid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
